// File: rtl/ni_inject_arbiter.sv
// Injection arbiter between the NI priority/normal source FIFOs and the router local port.
// Optional build macro NI_INJECT_ERR_EN adds the err_sticky protocol-error flag.
module ni_inject_arbiter #(
   parameter int FLIT_W     = 16,
   parameter int CREDITS    = 4,
   parameter int STARVE_MAX = 4,
   localparam int CW        = $clog2(CREDITS + 1),
   localparam int SW        = $clog2(STARVE_MAX + 1)
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              pri_empty,
   input  logic [FLIT_W-1:0] pri_data,
   output logic              pri_rd,
   input  logic              norm_empty,
   input  logic [FLIT_W-1:0] norm_data,
   output logic              norm_rd,
   input  logic              credit_in,
   output logic [FLIT_W-1:0] out_flit,
   output logic              out_valid,
   output logic              grant_pri,
   output logic              grant_norm,
   output logic [1:0]        dbg_state,
   output logic [CW-1:0]     dbg_credit_cnt,
   output logic [SW-1:0]     dbg_starve_cnt
`ifdef NI_INJECT_ERR_EN
   ,
   output logic              err_sticky
`endif
);

   // Handshake: a FIFO word is consumed in the cycle its *_rd is high (FWFT head),
   // and it is presented on out_flit with out_valid high on the following cycle.

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      SEND_PRI  = 2'd1,
      SEND_NORM = 2'd2
   } state_e;

   localparam logic [CW-1:0] CRED_MAX   = CW'(CREDITS);
   localparam logic [SW-1:0] STARVE_LIM = SW'(STARVE_MAX);
   localparam logic [2:0]    TYPE_HEAD  = 3'b001;
   localparam logic [2:0]    TYPE_TAIL  = 3'b110;

   state_e              state_q, state_d;
   logic [CW-1:0]       credit_q, credit_d;
   logic [SW-1:0]       starve_q, starve_d;
   logic [FLIT_W-1:0]   out_flit_q;
   logic                out_valid_q;
   logic                grant_pri_q;
   logic                grant_norm_q;

   logic                credit_ok;
   logic                pop;
   logic [FLIT_W-1:0]   pop_data;
   logic                pop_tail;

   assign credit_ok = (credit_q != '0);
   assign pri_rd    = (state_q == SEND_PRI)  && !pri_empty  && credit_ok;
   assign norm_rd   = (state_q == SEND_NORM) && !norm_empty && credit_ok;
   assign pop       = pri_rd || norm_rd;
   assign pop_data  = pri_rd ? pri_data : norm_data;
   assign pop_tail  = (pop_data[FLIT_W-1 -: 3] == TYPE_TAIL);

   always_comb begin
      state_d  = state_q;
      starve_d = starve_q;
      case (state_q)
         IDLE: begin
            if (!pri_empty && ((starve_q < STARVE_LIM) || norm_empty)) begin
               state_d = SEND_PRI;
            end else if (!norm_empty) begin
               state_d = SEND_NORM;
            end
         end
         SEND_PRI: begin
            if (pri_rd && pop_tail) begin
               state_d = IDLE;
               // Only a waiting normal packet counts as being starved.
               if (!norm_empty) begin
                  if (starve_q != STARVE_LIM) begin
                     starve_d = starve_q + SW'(1);
                  end
               end else begin
                  starve_d = '0;
               end
            end
         end
         SEND_NORM: begin
            if (norm_rd && pop_tail) begin
               state_d  = IDLE;
               starve_d = '0;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Pop and returned credit in the same cycle cancel; returns at full count saturate.
   always_comb begin
      credit_d = credit_q;
      if (pop && !credit_in) begin
         credit_d = credit_q - CW'(1);
      end else if (credit_in && !pop && (credit_q != CRED_MAX)) begin
         credit_d = credit_q + CW'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= IDLE;
         credit_q <= CRED_MAX;
         starve_q <= '0;
      end else begin
         state_q  <= state_d;
         credit_q <= credit_d;
         starve_q <= starve_d;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_flit_q   <= '0;
         out_valid_q  <= 1'b0;
         grant_pri_q  <= 1'b0;
         grant_norm_q <= 1'b0;
      end else begin
         out_valid_q  <= pop;
         if (pop) begin
            out_flit_q <= pop_data;
         end
         grant_pri_q  <= (state_q == SEND_PRI);
         grant_norm_q <= (state_q == SEND_NORM);
      end
   end

   assign out_flit       = out_flit_q;
   assign out_valid      = out_valid_q;
   assign grant_pri      = grant_pri_q;
   assign grant_norm     = grant_norm_q;
   assign dbg_state      = state_q;
   assign dbg_credit_cnt = credit_q;
   assign dbg_starve_cnt = starve_q;

`ifdef NI_INJECT_ERR_EN
   logic pop_head;
   logic first_q, first_d;
   logic err_q, err_d;

   assign pop_head = (pop_data[FLIT_W-1 -: 3] == TYPE_HEAD);

   // first_q marks that the next pop is the opening flit of a packet.
   always_comb begin
      first_d = first_q;
      err_d   = err_q;
      if (state_q == IDLE) begin
         first_d = 1'b1;
      end else if (pop) begin
         first_d = 1'b0;
      end
      if (credit_in && (credit_q == CRED_MAX)) begin
         err_d = 1'b1;
      end
      if (pop && first_q && !pop_head) begin
         err_d = 1'b1;
      end
      if (pop && !first_q && pop_head) begin
         err_d = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         first_q <= 1'b1;
         err_q   <= 1'b0;
      end else begin
         first_q <= first_d;
         err_q   <= err_d;
      end
   end

   assign err_sticky = err_q;
`endif

endmodule

// File: doc/ni_inject_arbiter.md
Name: ni_inject_arbiter

Overview:
- Sits between the NI's two source FIFOs and the router local injection port.
  - Priority FIFO: interrupt packets, a 2-flit head+tail sequence.
  - Normal FIFO: data packets of any length.
- Picks one FIFO per packet and keeps the grant for the whole packet, so flits from the two FIFOs never interleave.
- Meters flits out against a credit counter mirroring the router input buffer.
- Prevents priority traffic from starving normal traffic.

Parameters:
- FLIT_W, 16: flit width. Type field is [FLIT_W-1:FLIT_W-3]: 3'b001 = head, 3'b110 = tail, anything else = body.
- CREDITS, 4: router local input buffer depth; also the credit counter reset value.
- STARVE_MAX, 4: maximum consecutive priority packets granted while normal FIFO is non-empty.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- pri_empty  in  1  priority FIFO empty.
- pri_data  in  FLIT_W  priority FIFO head word; first-word-fall-through, valid when !pri_empty.
- pri_rd  out  1  pop priority FIFO, combinational.
- norm_empty  in  1  normal FIFO empty.
- norm_data  in  FLIT_W  normal FIFO head word; first-word-fall-through.
- norm_rd  out  1  pop normal FIFO, combinational.
- credit_in  in  1  one pulse = one router buffer slot freed.
- out_flit  out  FLIT_W  registered flit to router.
- out_valid  out  1  registered; out_flit valid this cycle.
- grant_pri  out  1  registered; a priority packet is in flight.
- grant_norm  out  1  registered; a normal packet is in flight.

Behaviour:
- Reset (async assert, sync release):
  - State IDLE, credit_cnt=CREDITS, starve_cnt=0.
  - out_flit=0, out_valid=0, grant_pri=0, grant_norm=0.
  - pri_rd=0 and norm_rd=0 while rst_n=0.
- States: IDLE, SEND_PRI, SEND_NORM.
- IDLE arbitration, evaluated every cycle:
  - If !pri_empty and (starve_cnt<STARVE_MAX or norm_empty): go to SEND_PRI.
  - Else if !norm_empty: go to SEND_NORM.
  - Else stay in IDLE.
  - No pops in IDLE; arbitration costs one cycle.
- Send rule in SEND_x:
  - x_rd=1 iff selected FIFO is non-empty and credit_cnt>0.
  - The popped word appears on out_flit with out_valid=1 on the next cycle (latency 1).
  - Otherwise out_valid=0 and out_flit holds its last value.
- Packet end:
  - Popping a tail-type flit sends the FSM to IDLE next cycle.
  - A head flit arriving mid-packet is forwarded as data; it does not restart the packet.
- Atomicity:
  - If the selected FIFO goes empty mid-packet, the FSM stays in SEND_x and stalls.
  - It never switches FIFO until the tail has been sent.
- Credits:
  - Decrement on a pop, increment on credit_in.
  - Pop and credit_in in the same cycle: count unchanged.
  - credit_in while credit_cnt==CREDITS: ignored, count saturates.
  - credit_cnt==0: no pop; the FSM holds state.
- Starvation counter:
  - A priority packet completes with norm_empty=0: starve_cnt increments, saturating at STARVE_MAX.
  - A normal packet completes, or a priority packet completes with norm_empty=1: starve_cnt clears to 0.
- grant_pri / grant_norm: registered decode of the state (SEND_PRI / SEND_NORM). Never both high.
- Reset mid-packet: everything returns to reset values immediately. Partially popped packets are lost; upstream flushes them.
- The block never pops both FIFOs in one cycle.

Optional Feature:
- Macro: NI_INJECT_ERR_EN.
- Defined: adds output err_sticky (1 bit, reset 0). It sets and holds until reset on any of:
  - credit_in while credit_cnt==CREDITS.
  - First flit popped in SEND_x is not head-type.
  - A second head popped before a tail.
- Flits are forwarded unchanged either way.
- Undefined: no port, no checking logic; credit overflow is silently saturated.

Test Plan:
- Single interrupt: pri FIFO holds {16'h2035, 16'hC000}, ample credits.
  - IDLE one cycle, then pri_rd high two consecutive cycles.
  - out_valid high for 2 cycles carrying 2035 then C000.
  - grant_pri high throughout; FSM back to IDLE after the tail.
- Contention: both FIFOs loaded at reset release, normal packet of 4 flits.
  - Priority packet goes first.
  - Normal packet follows intact with no interleaving; 4 contiguous out_valid cycles.
- Starvation, STARVE_MAX=4: normal FIFO non-empty, priority FIFO continuously refilled.
  - Exactly 4 priority packets, then 1 normal packet, then priority resumes.
  - starve_cnt shows 0→4→0.
- Credit exhaustion, CREDITS=4, no credit_in: 6-flit normal packet.
  - 4 flits sent, then stall with norm_rd=0.
  - A single credit_in pulse releases exactly one flit.
  - credit_in coincident with a pop leaves credit_cnt unchanged.
- Mid-packet underflow: normal head+body sent, FIFO empties, priority data arrives.
  - FSM stays SEND_NORM with no pri_rd.
  - Priority is granted only after the normal tail is pushed and sent.
- Async reset mid-packet: rst_n low between flit 2 and 3.
  - Outputs zero immediately without a clock edge.
  - credit_cnt=CREDITS after release.
  - NI_INJECT_ERR_EN build: missing head or credit overflow sets err_sticky, which holds until reset.
